// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle for the shared memory port arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        if_rsp_err;

  logic        ls_req_valid;
  logic        ls_req_wen;
  logic [63:0] ls_req_addr;
  logic [63:0] ls_req_wdata;
  logic [3:0]  ls_req_len;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [63:0] ls_rsp_rdata;
  logic        ls_rsp_err;

  logic        mem_req_valid;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [3:0]  mem_req_len;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid,
    output if_rsp_data, if_rsp_err,
    input  ls_req_valid, ls_req_wen,
    input  ls_req_addr, ls_req_wdata,
    input  ls_req_len,
    output ls_req_ready, ls_rsp_valid,
    output ls_rsp_rdata, ls_rsp_err,
    output mem_req_valid, mem_req_wen,
    output mem_req_addr, mem_req_wdata,
    output mem_req_len,
    input  mem_req_ready, mem_rsp_valid,
    input  mem_rsp_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid,
    input  if_rsp_data, if_rsp_err,
    output ls_req_valid, ls_req_wen,
    output ls_req_addr, ls_req_wdata,
    output ls_req_len,
    input  ls_req_ready, ls_rsp_valid,
    input  ls_rsp_rdata, ls_rsp_err,
    input  mem_req_valid, mem_req_wen,
    input  mem_req_addr, mem_req_wdata,
    input  mem_req_len,
    output mem_req_ready, mem_rsp_valid,
    output mem_rsp_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin ties instead of LS priority.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        owner_ls_q;
  logic        wen_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [3:0]  len_q;
  logic [7:0]  cnt_q;

  logic        if_vld_q;
  logic [63:0] if_data_q;
  logic        if_err_q;
  logic        ls_vld_q;
  logic [63:0] ls_data_q;
  logic        ls_err_q;

  logic        prefer_ls;
  logic        len_ok;
  logic        ls_take;
  logic        if_take;
  logic        accept;
  logic        bad_take;
  logic        rsp_hit;
  logic        time_out;

`ifdef MEM_ARB_RR_EN
  logic        last_ls_q;

  // Remember who won last so a tie goes to the other side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ls_q <= 1'b0;
    end else if (accept) begin
      last_ls_q <= ls_take;
    end
  end

  assign prefer_ls = ~last_ls_q;
`else
  assign prefer_ls = 1'b1;
`endif

  // Grant decision and request classification, IDLE only.
  always_comb begin
    len_ok = 1'b0;
    unique case (bus.ls_req_len)
      4'd1, 4'd2, 4'd4, 4'd8: len_ok = 1'b1;
      default:                len_ok = 1'b0;
    endcase
    ls_take  = rst
             & (state_q == S_IDLE)
             & bus.ls_req_valid
             & (~bus.if_req_valid | prefer_ls);
    if_take  = rst
             & (state_q == S_IDLE)
             & bus.if_req_valid
             & ~ls_take;
    accept   = ls_take | if_take;
    bad_take = ls_take & ~len_ok;
    rsp_hit  = (state_q == S_WAIT)
             & bus.mem_rsp_valid;
    time_out = (state_q == S_WAIT)
             & ~bus.mem_rsp_valid
             & (cnt_q == TO_LIMIT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !bad_take) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_hit || time_out) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: readies, memory request, response registers.
  always_comb begin
    bus.if_req_ready  = if_take;
    bus.ls_req_ready  = ls_take;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_wen   = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    bus.mem_req_len   = '0;
    if (state_q == S_ISSUE) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_req_wen   = wen_q;
      bus.mem_req_addr  = addr_q;
      bus.mem_req_wdata = wdata_q;
      bus.mem_req_len   = len_q;
    end
    bus.if_rsp_valid  = if_vld_q;
    bus.if_rsp_data   = if_data_q;
    bus.if_rsp_err    = if_err_q;
    bus.ls_rsp_valid  = ls_vld_q;
    bus.ls_rsp_rdata  = ls_data_q;
    bus.ls_rsp_err    = ls_err_q;
  end

  // Latch the granted request; fetch is always a 4-byte read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_ls_q <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      len_q      <= '0;
    end else if (accept && !bad_take) begin
      owner_ls_q <= ls_take;
      wen_q      <= ls_take & bus.ls_req_wen;
      addr_q     <= ls_take ? bus.ls_req_addr
                            : bus.if_req_addr;
      wdata_q    <= ls_take ? bus.ls_req_wdata
                            : '0;
      len_q      <= ls_take ? bus.ls_req_len
                            : 4'd4;
    end
  end

  // Response watchdog: counts WAIT cycles from issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      if (bus.mem_req_ready) begin
        cnt_q <= '0;
      end
    end else if (state_q == S_WAIT) begin
      if (!rsp_hit && !time_out) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // One-cycle response pulses; data/err hold between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_vld_q  <= 1'b0;
      if_data_q <= '0;
      if_err_q  <= 1'b0;
      ls_vld_q  <= 1'b0;
      ls_data_q <= '0;
      ls_err_q  <= 1'b0;
    end else begin
      if_vld_q <= 1'b0;
      ls_vld_q <= 1'b0;
      unique case (1'b1)
        bad_take: begin
          ls_vld_q  <= 1'b1;
          ls_data_q <= '0;
          ls_err_q  <= 1'b1;
        end
        rsp_hit: begin
          if (owner_ls_q) begin
            ls_vld_q  <= 1'b1;
            ls_data_q <= wen_q ? '0
                               : bus.mem_rsp_rdata;
            ls_err_q  <= 1'b0;
          end else begin
            if_vld_q  <= 1'b1;
            if_data_q <= {32'd0,
                          bus.mem_rsp_rdata[31:0]};
            if_err_q  <= 1'b0;
          end
        end
        time_out: begin
          if (owner_ls_q) begin
            ls_vld_q  <= 1'b1;
            ls_data_q <= '0;
            ls_err_q  <= 1'b1;
          end else begin
            if_vld_q  <= 1'b1;
            if_data_q <= '0;
            if_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
